// File: rtl/bf16_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf16_add_arbiter                                             |
// | Description : Round-robin arbiter that time-shares one bfloat16 adder      |
// |               between NREQ requesters, with one operation in flight.       |
// |               The winner's operands are captured, the adder is started     |
// |               with a one-cycle pulse, and the sum is returned tagged with  |
// |               the requester id.                                            |
// | Config      : BF16_ARB_TIMEOUT_EN - when defined, a WAIT-state watchdog    |
// |               aborts after TIMEOUT cycles with resp_sum=16'hFFFF and       |
// |               resp_err=1. When undefined, WAIT persists until add_done.    |
// | Ports       : clock, nreset        - clock, async active-low reset         |
// |               req_valid/req_a/req_b - per-requester operation (16b packed) |
// |               req_ready            - one-hot grant/accept pulse            |
// |               resp_valid/id/sum/err, resp_ready - result handshake         |
// |               add_start/add_a/add_b - adder command                        |
// |               add_done/add_sum     - adder completion                      |
// |               busy                 - arbiter not idle                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bf16_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [15:0]        resp_sum,
  output logic               resp_err,
  input  logic               resp_ready,
  output logic               add_start,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  input  logic               add_done,
  input  logic [15:0]        add_sum,
  output logic               busy
);

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ)) begin : g_param_check
    $error("bf16_add_arbiter: NREQ must be 2..16 and IDW must equal clog2(NREQ)");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("bf16_add_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [15:0]     op_a_q, op_a_d;
  logic [15:0]     op_b_q, op_b_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [15:0]     sum_q, sum_d;
  logic            err_q, err_d;

`ifdef BF16_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNTW-1:0] tmo_cnt_inc;
`endif

  // Unpacked views of the operand buses so the winner can be selected by id.
  logic [15:0] a_arr [NREQ];
  logic [15:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[16*gi +: 16];
    assign b_arr[gi] = req_b[16*gi +: 16];
  end

  // Round-robin scan: candidates are last_grant+1, last_grant+2, ... wrapping
  // modulo NREQ, so last_grant itself is considered last.
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    sum_d        = sum_q;
    err_d        = err_q;
    req_ready    = '0;
`ifdef BF16_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_cnt_inc  = tmo_cnt_q + CNTW'(1);
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          op_a_d              = a_arr[grant_id];
          op_b_d              = b_arr[grant_id];
          op_id_d             = grant_id;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef BF16_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        // A done pulse always wins over a watchdog expiry in the same cycle.
        if (add_done) begin
          sum_d   = add_sum;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
`ifdef BF16_ARB_TIMEOUT_EN
        else if (tmo_cnt_inc == CNTW'(TIMEOUT)) begin
          sum_d   = 16'hFFFF;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
`endif
      end
      ST_RESP: begin
        // Fairness pointer advances only once the result is consumed.
        if (resp_ready) begin
          last_grant_d = op_id_q;
          err_d        = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      sum_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      sum_q        <= sum_d;
      err_q        <= err_d;
    end
  end

`ifdef BF16_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
  assign resp_err = err_q;
`else
  // err_q never leaves 0 without the watchdog; tie the port off explicitly.
  logic err_unused;
  assign err_unused = err_q;
  assign resp_err   = 1'b0;
`endif

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = op_id_q;
  assign resp_sum   = sum_q;
  assign add_start  = (state_q == ST_ISSUE);
  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bf16_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bf16_add_arbiter                                          |
// | Description : Self-checking bench for bf16_add_arbiter with a 3-cycle      |
// |               behavioural adder and a grant/response scoreboard.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bf16_add_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 3;

  logic               clock = 1'b0;
  logic               nreset = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [15:0]        resp_sum;
  logic               resp_err;
  logic               resp_ready = 1'b1;
  logic               add_start;
  logic [15:0]        add_a;
  logic [15:0]        add_b;
  logic               add_done;
  logic [15:0]        add_sum;
  logic               busy;

  logic [15:0] op_a [NREQ];
  logic [15:0] op_b [NREQ];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
    end
  end

  bf16_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_err(resp_err), .resp_ready(resp_ready),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_sum(add_sum), .busy(busy)
  );

  // Behavioural adder: known pair 1.0+2.0 -> 3.0, otherwise a plain integer sum
  // (the arbiter only forwards the value, so any deterministic function works).
  function automatic logic [15:0] exp_sum(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;
    return a + b;
  endfunction

  logic        adder_dead = 1'b0;
  int          lat_cnt = 0;
  logic        model_done = 1'b0;
  logic [15:0] model_sum = '0;
  logic [15:0] pa = '0, pb = '0;
  logic        inj_done = 1'b0;
  logic [15:0] inj_sum = '0;

  always @(posedge clock) begin
    model_done <= 1'b0;
    if (add_start) begin
      lat_cnt <= LAT - 1;
      pa      <= add_a;
      pb      <= add_b;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !adder_dead) begin
        model_done <= 1'b1;
        model_sum  <= exp_sum(pa, pb);
      end
    end
  end

  assign add_done = model_done | inj_done;
  assign add_sum  = inj_done ? inj_sum : model_sum;

  // Scoreboard: independent round-robin model predicts each grant and pushes
  // the expected response; the response handshake pops and compares.
  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    a;
    logic [15:0]    b;
    logic [15:0]    sum;
    logic           err;
  } exp_t;

  exp_t           sb_q[$];
  exp_t           m_e;
  logic [IDW-1:0] m_last = IDW'(NREQ - 1);
  logic           m_free = 1'b1;
  logic [NREQ-1:0] m_exp_rdy;
  int             m_win;
  int             m_idx;

  always @(negedge clock) begin
    if (!nreset) begin
      sb_q.delete();
      m_last = IDW'(NREQ - 1);
      m_free = 1'b1;
    end else begin
      m_exp_rdy = '0;
      m_win     = -1;
      if (m_free) begin
        for (int k = 1; k <= NREQ; k++) begin
          m_idx = (int'(m_last) + k) % NREQ;
          if (m_win < 0 && req_valid[m_idx]) m_win = m_idx;
        end
      end
      if (m_win >= 0) m_exp_rdy[m_win] = 1'b1;
      checks++;
      if (req_ready !== m_exp_rdy) begin
        errors++;
        $display("FAIL grant: req_ready=%b expected %b", req_ready, m_exp_rdy);
      end
      if (m_win >= 0) begin
        m_e.id  = IDW'(m_win);
        m_e.a   = op_a[m_win];
        m_e.b   = op_b[m_win];
        m_e.err = adder_dead;
        m_e.sum = adder_dead ? 16'hFFFF : exp_sum(op_a[m_win], op_b[m_win]);
        sb_q.push_back(m_e);
        m_free = 1'b0;
      end
      if (add_start) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL add_operands: add_start with no granted op");
        end else if (add_a !== sb_q[0].a || add_b !== sb_q[0].b) begin
          errors++;
          $display("FAIL add_operands: a=%h b=%h expected a=%h b=%h",
                   add_a, add_b, sb_q[0].a, sb_q[0].b);
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: id=%0d sum=%h with empty scoreboard", resp_id, resp_sum);
        end else begin
          m_e = sb_q.pop_front();
          if (resp_id !== m_e.id || resp_sum !== m_e.sum || resp_err !== m_e.err) begin
            errors++;
            $display("FAIL resp: id=%0d sum=%h err=%b expected id=%0d sum=%h err=%b",
                     resp_id, resp_sum, resp_err, m_e.id, m_e.sum, m_e.err);
          end
          m_last = m_e.id;
        end
        m_free = 1'b1;
      end
    end
  end

  task automatic drain;
    int c;
    c = 0;
    while (c < 60 && (busy || sb_q.size() != 0)) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (busy || sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b pending=%0d expected idle and empty", busy, sb_q.size());
    end
  endtask

  task automatic test_reset;
    nreset    = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_sum, resp_err, add_start, add_a, add_b, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b id=%0d sum=%h err=%b st=%b a=%h b=%h busy=%b expected all 0",
               req_ready, resp_valid, resp_id, resp_sum, resp_err, add_start, add_a, add_b, busy);
    end
    @(posedge clock); #1 nreset = 1'b1;
  endtask

  task automatic test_single;
    int  rdy_cyc, start_cyc;
    bit  got;
    logic [IDW-1:0] gid;
    logic [15:0]    gsum;
    rdy_cyc = 0; start_cyc = 0; got = 0; gid = '0; gsum = '0;
    op_a[0] = 16'h3F80;
    op_b[0] = 16'h4000;
    @(posedge clock); #1 req_valid = 4'b0001;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (req_ready != 0) rdy_cyc++;
      if (add_start) start_cyc++;
      if (resp_valid) begin
        got  = 1;
        gid  = resp_id;
        gsum = resp_sum;
      end
      if (req_ready[0]) begin
        @(posedge clock); #1 req_valid = '0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_resp_timeout: resp_valid=0 expected 1");
    end
    checks++;
    if (rdy_cyc != 1) begin errors++; $display("FAIL single_ready_cycles: %0d expected 1", rdy_cyc); end
    checks++;
    if (start_cyc != 1) begin errors++; $display("FAIL single_start_pulses: %0d expected 1", start_cyc); end
    checks++;
    if (gid !== 2'd0 || gsum !== 16'h4040) begin
      errors++;
      $display("FAIL single_result: id=%0d sum=%h expected id=0 sum=4040", gid, gsum);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [IDW-1:0] ord [5];
    int n;
    n = 0;
    @(posedge clock); #1 nreset = 1'b0;
    @(posedge clock); #1 nreset = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clock);
      if (resp_valid && resp_ready) begin
        ord[n] = resp_id;
        n++;
      end
    end
    @(posedge clock); #1 req_valid = '0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_count: %0d responses expected 5", n); end
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        checks++;
        if (ord[i] !== IDW'(i % NREQ)) begin
          errors++;
          $display("FAIL rr_order[%0d]: id=%0d expected %0d", i, ord[i], i % NREQ);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure;
    bit got, stable, quiet;
    int hs;
    logic [IDW-1:0] cid;
    logic [15:0]    csum;
    got = 0; stable = 1; quiet = 1; hs = 0; cid = '0; csum = '0;
    @(posedge clock); #1 resp_ready = 1'b0; req_valid = 4'b0100;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (req_ready[2]) begin
        @(posedge clock); #1 req_valid = 4'b1000;
      end
      if (resp_valid) begin
        got = 1; cid = resp_id; csum = resp_sum;
      end
    end
    checks++;
    if (!got || cid !== 2'd2 || csum !== exp_sum(op_a[2], op_b[2])) begin
      errors++;
      $display("FAIL bp_result: got=%b id=%0d sum=%h expected id=2 sum=%h",
               got, cid, csum, exp_sum(op_a[2], op_b[2]));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (!resp_valid || resp_id !== cid || resp_sum !== csum) stable = 0;
      if (req_ready !== '0) quiet = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable: resp changed while stalled, expected stable"); end
    checks++;
    if (!quiet) begin errors++; $display("FAIL bp_no_grant: req_ready seen in RESP, expected none"); end
    @(posedge clock); #1 resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (resp_valid && resp_ready) hs++;
      if (req_ready[3]) begin
        @(posedge clock); #1 req_valid = '0;
      end
    end
    checks++;
    if (hs != 1) begin errors++; $display("FAIL bp_handshakes: %0d expected 1", hs); end
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_in_wait;
    bit seen, any_resp, any_busy;
    seen = 0; any_resp = 0; any_busy = 0;
    @(posedge clock); #1 req_valid = 4'b0010;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (add_start) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_wait_start: add_start=0 expected 1"); end
    @(posedge clock); #1 req_valid = '0; nreset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_sum, resp_err, add_start, add_a, add_b, busy} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: rv=%b busy=%b a=%h b=%h expected all 0", resp_valid, busy, add_a, add_b);
    end
    @(posedge clock); #1 nreset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (resp_valid) any_resp = 1;
      if (busy) any_busy = 1;
    end
    checks++;
    if (any_resp || any_busy) begin
      errors++;
      $display("FAIL rst_wait_late_done: resp_valid=%b busy=%b expected 0 0", any_resp, any_busy);
    end
    @(posedge clock); #1 req_valid = 4'b1111;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_wait_next_grant: req_ready=%b expected 0001", req_ready);
    end
    @(posedge clock); #1 req_valid = '0;
    drain();
  endtask

  task automatic test_spurious_done;
    bit seen;
    seen = 0;
    @(posedge clock); #1 inj_sum = 16'hDEAD; inj_done = 1'b1;
    @(posedge clock); #1 inj_done = 1'b0;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: resp_valid=%b busy=%b expected 0 0", resp_valid, busy);
    end
    @(posedge clock); #1 req_valid = 4'b0001; op_a[0] = 16'h3F00; op_b[0] = 16'h0123;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (add_start) seen = 1;
    end
    inj_done  = 1'b1;
    req_valid = '0;
    @(negedge clock);
    inj_done = 1'b0;
    checks++;
    if (!seen || resp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_done: seen=%b resp_valid=%b busy=%b expected 1 0 1", seen, resp_valid, busy);
    end
    drain();
  endtask

`ifdef BF16_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit seen, got;
    int n;
    seen = 0; got = 0; n = 0;
    adder_dead = 1'b1;
    @(posedge clock); #1 req_valid = 4'b0001;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (add_start) seen = 1;
    end
    @(posedge clock); #1 req_valid = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      n++;
      if (resp_valid) got = 1;
    end
    checks++;
    if (!got || n != TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_latency: got=%b cycles=%0d expected %0d", got, n, TIMEOUT + 1);
    end
    checks++;
    if (resp_sum !== 16'hFFFF || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_result: sum=%h err=%b expected FFFF 1", resp_sum, resp_err);
    end
    @(negedge clock);
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: err=%b expected 0", resp_err); end
    adder_dead = 1'b0;
    drain();
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 16'h3F80 + 16'(i * 16'h0110);
      op_b[i] = 16'h4000 + 16'(i * 16'h0021);
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wait();
    test_spurious_done();
`ifdef BF16_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
